// File: rtl/hydra_pkg.sv
// Shared constants and id types for the write-side SRAM ownership logic.
package hydra_pkg;
    localparam int PORT_NUM = 16;
    localparam int SRAM_NUM = 32;

    typedef logic [3:0] port_id_t;
    typedef logic [5:0] sram_id_t;

    // Out-of-range SRAM id meaning "no SRAM".
    localparam sram_id_t SRAM_NONE = 6'd32;
endpackage

// File: rtl/claim_picker.sv
// One-hot winner select for the claimers of a single SRAM.
// The winner is the first requesting port at or after ptr, counting upward
// with wrap. A pointer tied to zero gives plain lowest-index-wins.
module claim_picker
    import hydra_pkg::port_id_t;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] req,
    input  port_id_t     ptr,
    output logic [N-1:0] grant
);

    port_id_t idx;
    logic     found;

    // Walk the ports starting at the pointer and keep the first requester.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = ptr + port_id_t'(i);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_claim_arbiter.sv
// Central write-side SRAM occupancy owner: conflict-free scan indices, free
// flags, claim arbitration and per-port ownership tracking.
// Build option: CLAIM_RR_PRIORITY_EN selects a rotating priority pointer for
// claim conflicts; without it the lowest port index wins.
module sram_claim_arbiter
    import hydra_pkg::port_id_t, hydra_pkg::sram_id_t, hydra_pkg::SRAM_NONE;
#(
    parameter int PORT_NUM = hydra_pkg::PORT_NUM,
    parameter int SRAM_NUM = hydra_pkg::SRAM_NUM
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [PORT_NUM*5-1:0] scan_sram,
    output logic [PORT_NUM-1:0]   scan_free,
    input  logic [PORT_NUM-1:0]   claim_valid,
    input  logic [PORT_NUM*6-1:0] claim_sram,
    output logic [PORT_NUM-1:0]   claim_grant,
    output logic [PORT_NUM-1:0]   claim_reject,
    input  logic [PORT_NUM-1:0]   release_valid,
    output logic [PORT_NUM*6-1:0] port_sram
);

    logic [4:0]          scan_base_reg;
    logic [SRAM_NUM-1:0] occ_valid_reg;
    port_id_t            occ_owner_reg [SRAM_NUM];
    sram_id_t            port_sram_reg [PORT_NUM];
    logic [PORT_NUM-1:0] grant_reg;
    logic [PORT_NUM-1:0] reject_reg;

    logic [PORT_NUM-1:0] claim_ok;
    logic [PORT_NUM-1:0] win_by_sram [SRAM_NUM];
    logic [SRAM_NUM-1:0] conflict_vec;
    logic [PORT_NUM-1:0] grant_next;
    port_id_t            prio_ptr;

`ifdef CLAIM_RR_PRIORITY_EN
    port_id_t ptr_reg;

    // Rotate priority once per cycle that saw any multi-claimer SRAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (|conflict_vec) begin
            ptr_reg <= ptr_reg + 4'd1;
        end
    end

    assign prio_ptr = ptr_reg;
`else
    assign prio_ptr = '0;
`endif

    // Per-port scan index, free flag, held SRAM and port-local claim legality.
    // Even offsets of 2*p keep all sixteen probes on distinct SRAMs.
    for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_port
        logic [4:0] scan_idx;
        assign scan_idx                = scan_base_reg + 5'(2 * gi);
        assign scan_sram[gi*5 +: 5]    = scan_idx;
        assign scan_free[gi]           = ~occ_valid_reg[scan_idx];
        assign port_sram[gi*6 +: 6]    = port_sram_reg[gi];
        assign claim_ok[gi]            = claim_valid[gi]
                                         && (port_sram_reg[gi] == SRAM_NONE)
                                         && !release_valid[gi];
    end

    // One picker per SRAM, fed by the legal claims aimed at that SRAM while
    // it is free in the pre-update table.
    for (genvar gj = 0; gj < SRAM_NUM; gj++) begin : g_sram
        logic [PORT_NUM-1:0] req;

        // Collect the ports whose legal claim targets this SRAM.
        always_comb begin
            req = '0;
            for (int p = 0; p < PORT_NUM; p++) begin
                req[p] = claim_ok[p] && !occ_valid_reg[gj]
                         && (claim_sram[p*6 +: 6] == sram_id_t'(gj));
            end
        end

        assign conflict_vec[gj] = |(req & (req - 1'b1));

        claim_picker #(.N(PORT_NUM)) u_pick (
            .req   (req),
            .ptr   (prio_ptr),
            .grant (win_by_sram[gj])
        );
    end

    // Each port claims at most one SRAM, so OR-ing the winners is exact.
    always_comb begin
        grant_next = '0;
        for (int s = 0; s < SRAM_NUM; s++) begin
            grant_next = grant_next | win_by_sram[s];
        end
    end

    // Scan counter, response pulses, occupancy flags and per-port holdings.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_base_reg <= '0;
            occ_valid_reg <= '0;
            grant_reg     <= '0;
            reject_reg    <= '0;
            for (int p = 0; p < PORT_NUM; p++) begin
                port_sram_reg[p] <= SRAM_NONE;
            end
        end else begin
            scan_base_reg <= scan_base_reg + 5'd1;
            grant_reg     <= grant_next;
            reject_reg    <= claim_valid & ~grant_next;
            for (int p = 0; p < PORT_NUM; p++) begin
                // A releasing port is never granted in the same cycle, and a
                // released SRAM was busy so it cannot be granted either.
                if (release_valid[p] && (port_sram_reg[p] != SRAM_NONE)) begin
                    port_sram_reg[p] <= SRAM_NONE;
                    if (occ_owner_reg[port_sram_reg[p][4:0]] == port_id_t'(p)) begin
                        occ_valid_reg[port_sram_reg[p][4:0]] <= 1'b0;
                    end
                end
                if (grant_next[p]) begin
                    port_sram_reg[p]                    <= claim_sram[p*6 +: 6];
                    occ_valid_reg[claim_sram[p*6 +: 5]] <= 1'b1;
                end
            end
        end
    end

    // Owner ids are only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        for (int p = 0; p < PORT_NUM; p++) begin
            if (!rst && grant_next[p]) begin
                occ_owner_reg[claim_sram[p*6 +: 5]] <= port_id_t'(p);
            end
        end
    end

    assign claim_grant  = grant_reg;
    assign claim_reject = reject_reg;

endmodule

// File: tb/tb_sram_claim_arbiter.sv
// Self-checking bench for sram_claim_arbiter: directed scenarios plus a
// randomized run against a behavioural occupancy model.
// Honours CLAIM_RR_PRIORITY_EN for the expected conflict winners.
module tb_sram_claim_arbiter;

    logic        clk;
    logic        rst;
    logic [79:0] scan_sram;
    logic [15:0] scan_free;
    logic [15:0] claim_valid;
    logic [95:0] claim_sram;
    logic [15:0] claim_grant;
    logic [15:0] claim_reject;
    logic [15:0] release_valid;
    logic [95:0] port_sram;

    int n_tests;
    int n_fail;

    // Behavioural model: who owns each SRAM (-1 = free), what each port holds
    // (32 = none), scan base, priority pointer and the expected pulses.
    int          m_owner [32];
    int          m_held  [16];
    int          m_base;
    int          m_ptr;
    logic [15:0] exp_grant;
    logic [15:0] exp_reject;

`ifdef CLAIM_RR_PRIORITY_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    sram_claim_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .scan_sram     (scan_sram),
        .scan_free     (scan_free),
        .claim_valid   (claim_valid),
        .claim_sram    (claim_sram),
        .claim_grant   (claim_grant),
        .claim_reject  (claim_reject),
        .release_valid (release_valid),
        .port_sram     (port_sram)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int          cnt;
        bit          conflict;
        bit          found;
        int          q;
        logic [15:0] elig;
        logic [15:0] win;
        if (rst) begin
            for (int s = 0; s < 32; s++) m_owner[s] = -1;
            for (int p = 0; p < 16; p++) m_held[p] = 32;
            m_base     = 0;
            m_ptr      = 0;
            exp_grant  = '0;
            exp_reject = '0;
            return;
        end
        win      = '0;
        conflict = 0;
        for (int s = 0; s < 32; s++) begin
            cnt = 0;
            for (int p = 0; p < 16; p++) begin
                elig[p] = claim_valid[p] && (int'(claim_sram[p*6 +: 6]) == s)
                          && (m_owner[s] < 0) && (m_held[p] == 32) && !release_valid[p];
                if (elig[p]) cnt++;
            end
            if (cnt >= 2) conflict = 1;
            found = 0;
            for (int k = 0; k < 16; k++) begin
                q = (m_ptr + k) % 16;
                if (!found && elig[q]) begin
                    win[q] = 1'b1;
                    found  = 1;
                end
            end
        end
        exp_grant  = win;
        exp_reject = claim_valid & ~win;
        for (int p = 0; p < 16; p++) begin
            if (release_valid[p] && m_held[p] != 32) begin
                m_owner[m_held[p]] = -1;
                m_held[p]          = 32;
            end
        end
        for (int p = 0; p < 16; p++) begin
            if (win[p]) begin
                m_held[p]              = int'(claim_sram[p*6 +: 6]);
                m_owner[m_held[p]]     = p;
            end
        end
        if (RR && conflict) m_ptr = (m_ptr + 1) % 16;
        m_base = (m_base + 1) % 32;
    endtask

    // One clock: update the model, take the edge, sample 1 time unit later,
    // then drop the one-cycle request pulses.
    task automatic tick();
        logic [15:0] cv;
        logic [15:0] rv;
        cv = claim_valid;
        rv = release_valid;
        model_step();
        @(posedge clk);
        #1;
        if (cv != 0 || rv != 0 || rst)
            $display("[TB] t=%0t rst=%0b claim=%04h release=%04h grant=%04h reject=%04h",
                     $time, rst, cv, rv, claim_grant, claim_reject);
        claim_valid   = '0;
        release_valid = '0;
    endtask

    task automatic put_claim(input int p, input int s);
        claim_valid[p]       = 1'b1;
        claim_sram[p*6 +: 6] = 6'(s);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if (scan_sram[4:0] !== 5'd0 || scan_sram[25 +: 5] !== 5'd10) begin
            n_fail++;
            $display("FAIL reset_scan: scan0=%0d scan5=%0d expected 0 and 10", scan_sram[4:0], scan_sram[25 +: 5]);
        end
        n_tests++;
        if (scan_free !== 16'hFFFF || claim_grant !== 16'h0 || claim_reject !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_flags: free=%04h grant=%04h reject=%04h expected ffff 0 0", scan_free, claim_grant, claim_reject);
        end
        n_tests++;
        if (port_sram !== {16{6'd32}}) begin
            n_fail++;
            $display("FAIL reset_port_sram: got %024h expected all 32", port_sram);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (scan_sram[4:0] !== 5'd1) begin
            n_fail++;
            $display("FAIL scan_step: scan0=%0d expected 1", scan_sram[4:0]);
        end
        for (int i = 0; i < 31; i++) tick();
        n_tests++;
        if (scan_sram[4:0] !== 5'd0 || scan_sram[25 +: 5] !== 5'd10) begin
            n_fail++;
            $display("FAIL scan_wrap: scan0=%0d scan5=%0d expected 0 and 10", scan_sram[4:0], scan_sram[25 +: 5]);
        end
    endtask

    task automatic test_single_claim();
        int d;
        int p;
        do_reset();
        put_claim(3, 7);
        tick();
        n_tests++;
        if (claim_grant !== 16'h0008 || claim_reject !== 16'h0) begin
            n_fail++;
            $display("FAIL single_grant: grant=%04h reject=%04h expected 0008 0000", claim_grant, claim_reject);
        end
        n_tests++;
        if (port_sram[18 +: 6] !== 6'd7) begin
            n_fail++;
            $display("FAIL single_port_sram: got %0d expected 7", port_sram[18 +: 6]);
        end
        d = (7 - m_base + 32) % 32;
        if (d % 2 != 0) begin
            tick();
            d = (7 - m_base + 32) % 32;
        end
        p = d / 2;
        n_tests++;
        if (scan_free[p] !== 1'b0 || scan_sram[p*5 +: 5] !== 5'd7) begin
            n_fail++;
            $display("FAIL single_scan_busy: port %0d scans %0d free=%0b expected 7 free=0", p, scan_sram[p*5 +: 5], scan_free[p]);
        end
    endtask

    task automatic test_conflict();
        logic [15:0] want;
        do_reset();
        put_claim(2, 12);
        put_claim(9, 12);
        tick();
        n_tests++;
        if (claim_grant !== 16'h0004 || claim_reject !== 16'h0200) begin
            n_fail++;
            $display("FAIL conflict_ptr0: grant=%04h reject=%04h expected 0004 0200", claim_grant, claim_reject);
        end
        release_valid[2] = 1'b1;
        tick();
        put_claim(0, 13);
        put_claim(1, 13);
        tick();
        release_valid = 16'h0003;
        tick();
        put_claim(0, 14);
        put_claim(1, 14);
        tick();
        release_valid = 16'h0003;
        tick();
        put_claim(2, 12);
        put_claim(9, 12);
        tick();
        want = RR ? 16'h0200 : 16'h0004;
        n_tests++;
        if (claim_grant !== want || claim_reject !== (16'h0204 & ~want)) begin
            n_fail++;
            $display("FAIL conflict_ptr3: grant=%04h reject=%04h expected %04h %04h", claim_grant, claim_reject, want, 16'h0204 & ~want);
        end
    endtask

    task automatic test_release_claim();
        do_reset();
        put_claim(4, 20);
        tick();
        release_valid[4] = 1'b1;
        put_claim(6, 20);
        tick();
        n_tests++;
        if (claim_reject !== 16'h0040 || claim_grant !== 16'h0 || port_sram[24 +: 6] !== 6'd32) begin
            n_fail++;
            $display("FAIL release_same_cycle: grant=%04h reject=%04h port4=%0d expected 0000 0040 32", claim_grant, claim_reject, port_sram[24 +: 6]);
        end
        put_claim(6, 20);
        tick();
        n_tests++;
        if (claim_grant !== 16'h0040 || port_sram[36 +: 6] !== 6'd20) begin
            n_fail++;
            $display("FAIL reclaim: grant=%04h port6=%0d expected 0040 20", claim_grant, port_sram[36 +: 6]);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        put_claim(0, 32);
        tick();
        n_tests++;
        if (claim_reject !== 16'h0001 || claim_grant !== 16'h0) begin
            n_fail++;
            $display("FAIL claim_none: grant=%04h reject=%04h expected 0000 0001", claim_grant, claim_reject);
        end
        put_claim(1, 5);
        tick();
        put_claim(1, 6);
        tick();
        n_tests++;
        if (claim_reject !== 16'h0002 || claim_grant !== 16'h0 || port_sram[6 +: 6] !== 6'd5) begin
            n_fail++;
            $display("FAIL claim_while_holding: grant=%04h reject=%04h port1=%0d expected 0000 0002 5", claim_grant, claim_reject, port_sram[6 +: 6]);
        end
        put_claim(2, 5);
        tick();
        n_tests++;
        if (claim_reject !== 16'h0004 || port_sram[12 +: 6] !== 6'd32) begin
            n_fail++;
            $display("FAIL claim_busy: reject=%04h port2=%0d expected 0004 32", claim_reject, port_sram[12 +: 6]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int p = 0; p < 16; p++) put_claim(p, 2 * p + 1);
        tick();
        n_tests++;
        if (claim_grant !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL fill_all: grant=%04h expected ffff", claim_grant);
        end
        for (int p = 0; p < 16; p++) put_claim(p, 2 * p);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (port_sram !== {16{6'd32}} || scan_free !== 16'hFFFF || claim_grant !== 16'h0 || claim_reject !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid: free=%04h grant=%04h reject=%04h port_sram=%024h", scan_free, claim_grant, claim_reject, port_sram);
        end
    endtask

    task automatic test_random();
        logic [95:0] exp_ps;
        logic [15:0] exp_free;
        logic [79:0] exp_scan;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            for (int p = 0; p < 16; p++) begin
                if ($urandom_range(2) == 0)
                    put_claim(p, ($urandom_range(15) == 0) ? 32 : int'($urandom_range(7)) * 3);
                release_valid[p] = ($urandom_range(5) == 0);
            end
            tick();
            for (int p = 0; p < 16; p++) begin
                exp_ps[p*6 +: 6]   = 6'(m_held[p]);
                exp_scan[p*5 +: 5] = 5'((m_base + 2 * p) % 32);
                exp_free[p]        = (m_owner[(m_base + 2 * p) % 32] < 0);
            end
            n_tests++;
            if (claim_grant !== exp_grant || claim_reject !== exp_reject) begin
                n_fail++;
                $display("FAIL rand_pulses cyc %0d: grant=%04h reject=%04h expected %04h %04h", c, claim_grant, claim_reject, exp_grant, exp_reject);
            end
            n_tests++;
            if (port_sram !== exp_ps) begin
                n_fail++;
                $display("FAIL rand_port_sram cyc %0d: got %024h expected %024h", c, port_sram, exp_ps);
            end
            n_tests++;
            if (scan_sram !== exp_scan || scan_free !== exp_free) begin
                n_fail++;
                $display("FAIL rand_scan cyc %0d: scan=%020h free=%04h expected %020h %04h", c, scan_sram, scan_free, exp_scan, exp_free);
            end
        end
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        claim_valid   = '0;
        claim_sram    = {16{6'd32}};
        release_valid = '0;
        test_reset();
        test_single_claim();
        test_conflict();
        test_release_claim();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_claim_arbiter.md
# sram_claim_arbiter

Central owner of write-side SRAM occupancy for the 16 input ports. It drives each port's SRAM matcher with a conflict-free scan index every cycle, reports whether the scanned SRAM is free, and arbitrates the SRAM claims that ports issue after a successful match. It also tracks per-port ownership until the port releases its SRAM at end of packet.

## Interface
- Parameters:
  - PORT_NUM, 16, number of requesting ports (4-bit port id).
  - SRAM_NUM, 32, number of SRAMs (5-bit index; 6-bit value 32 = none).
- Ports:
  - clk  in  1  clock.
  - rst  in  1  synchronous, active-high reset.
  - scan_sram  out  PORT_NUM*5  per-port SRAM index to probe this cycle.
  - scan_free  out  PORT_NUM  per-port: scanned SRAM currently unowned.
  - claim_valid  in  PORT_NUM  per-port claim request, one-cycle pulse.
  - claim_sram  in  PORT_NUM*6  per-port claimed SRAM; 32 = none.
  - claim_grant  out  PORT_NUM  per-port grant pulse.
  - claim_reject  out  PORT_NUM  per-port reject pulse.
  - release_valid  in  PORT_NUM  per-port release of its held SRAM, one-cycle pulse.
  - port_sram  out  PORT_NUM*6  SRAM held by each port; 32 = none.

## Operation
- Scan: 5-bit scan_base increments by 1 every cycle and wraps 31→0. scan_sram[p] = (scan_base + 2*p) mod 32, so no two ports probe the same SRAM in one cycle.
- Occupancy table: occ_valid[32] and occ_owner[32] (4-bit). scan_free[p] = ~occ_valid[scan_sram[p]], combinational from the current table.
- Claim evaluation (registered) uses the table as it stands before this cycle's updates. A claim from port p is rejected if any of the following holds:
  - claim_sram == 32;
  - the claimed SRAM has occ_valid = 1;
  - port p already holds an SRAM (port_sram[p] != 32);
  - port p asserts release_valid in the same cycle;
  - another port wins the same SRAM.
- Conflict: when several valid claims target the same free SRAM, exactly one wins according to the priority rule (see Configuration). The others are rejected.
- Grant: sets occ_valid = 1, occ_owner = p, and port_sram[p] = the claimed SRAM.
- Release: when port p asserts release_valid and holds SRAM s, clear occ_valid[s] and set port_sram[p] = 32. A release from a port holding nothing is ignored.
- Same-cycle release of SRAM s and a claim of s by another port: the claim is rejected because it is evaluated against pre-release state. s becomes free on the next cycle.
- Every claim_valid pulse produces exactly one grant or one reject pulse for that port, never both.

## Timing
- Reset values:
  - scan_base = 0, so scan_sram[p] = 2p mod 32;
  - scan_free all 1;
  - claim_grant = 0, claim_reject = 0;
  - port_sram all 32;
  - occ_valid all 0;
  - priority pointer = 0.
- Claim latency: claim_valid in cycle N → claim_grant or claim_reject high in cycle N+1 for one cycle. The table and port_sram update at the same edge, so scan_free reflects the grant in cycle N+1.
- Release latency: release_valid in cycle N → port_sram = 32 and the SRAM shows free in scan_free from cycle N+1.
- Back-to-back claims from different ports in consecutive cycles are supported at full rate.
- rst asserted mid-operation clears all ownership at the next edge. Claims pending in that cycle produce neither grant nor reject.

## Configuration
- CLAIM_RR_PRIORITY_EN defined: a 4-bit rotating priority pointer selects the conflict winner.
  - The winner is the first claiming port at or after the pointer, counting upward mod 16.
  - The pointer advances by 1 in every cycle in which at least one conflict (two or more valid claimers on the same SRAM) occurs.
- CLAIM_RR_PRIORITY_EN undefined: fixed priority, lowest port index wins. The pointer register is not built.

## Structure
- Shared package hydra_pkg holds:
  - PORT_NUM and SRAM_NUM;
  - SRAM_NONE = 6'd32;
  - typedefs port_id_t (4-bit) and sram_id_t (6-bit).
- One sub-module, claim_picker: takes a PORT_NUM-bit request mask and the priority pointer, and returns a one-hot winner. It is instantiated once per SRAM; each instance's mask is built from the claims targeting that SRAM.

## Test plan
- Reset release: scan_sram[0]=0, scan_sram[5]=10; next cycle scan_sram[0]=1. After 32 cycles scan_sram[0]=0 again. scan_free all 1.
- Single claim: port 3 claims SRAM 7 in cycle N → claim_grant[3] in N+1, port_sram[3]=7. Any port scanning 7 sees scan_free=0 from N+1.
- Conflict (RR build, pointer=0): ports 2 and 9 claim SRAM 12 together → port 2 granted, port 9 rejected, pointer becomes 1. Repeated with pointer=3 → port 9 granted.
- Same-cycle release/claim: port 4 holds SRAM 20 and releases it while port 6 claims 20 → port 6 rejected. Port 6 reclaims next cycle → granted.
- Illegal claims: claim_sram=32 → reject. Port 1 holding SRAM 5 claims SRAM 6 → reject, port_sram[1] stays 5.
- Reset mid-operation: ports 0–15 each hold an SRAM and rst pulses for one cycle → all port_sram=32, all scan_free=1, no grant/reject pulse.
